// File: rtl/if_fetch_stage_pkg.sv
// ============================================================================
// if_fetch_stage_pkg : shared widths, bubble word and fetch FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package if_fetch_stage_pkg;

    localparam int InstAddrWidth   = 32;
    localparam int InstDataWidth   = 32;
    localparam logic [InstDataWidth-1:0] ZeroWord = '0;   // sll $0,$0,0 (nop)
    localparam logic BranchEnable  = 1'b1;

    localparam int FetchStateWidth = 1;

    typedef enum logic [FetchStateWidth-1:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with flush > load > hold priority
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = InstAddrWidth,
    parameter int DATA_W = InstDataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_plus4_d = pc_plus4_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        if (flush_i) begin
            pc_plus4_d = '0;
            inst_d     = DATA_W'(ZeroWord);
            valid_d    = 1'b0;
        end else if (load_i) begin
            pc_plus4_d = pc_plus4_i;
            inst_d     = inst_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_plus4_q <= '0;
            inst_q     <= DATA_W'(ZeroWord);
            valid_q    <= 1'b0;
        end else begin
            pc_plus4_q <= pc_plus4_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_plus4_o = pc_plus4_q;
    assign inst_o     = inst_q;
    assign valid_o    = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage : PC, req/ack instruction fetch FSM, redirect/kill, IF/ID
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrWidth,
    parameter int                DATA_W   = InstDataWidth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ID,
    input  logic              is_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              is_rst_IF_ID,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_plus4_ID,
    output logic [DATA_W-1:0] inst_ID,
    output logic              valid_ID,
    output logic              fetch_busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] buf_pc4_q, buf_pc4_d;
    logic [DATA_W-1:0] buf_inst_q, buf_inst_d;

    logic              redirect;
    logic              ack_ok;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] req_plus4;
    logic              id_load, id_flush;
    logic [ADDR_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_inst;

    assign redirect  = ((is_branch == BranchEnable) | is_rst_IF_ID) & ~stall_ID;
    assign target    = branch_address & ~ADDR_W'(3);
    assign req_plus4 = req_addr_q + ADDR_W'(4);
    assign ack_ok    = (state_q == S_FETCH) & imem_ack & ~kill_q;

    // Draining the hold buffer and a live fetch never load IF/ID in the same cycle
    assign id_pc4  = (state_q == S_HOLD) ? buf_pc4_q  : req_plus4;
    assign id_inst = (state_q == S_HOLD) ? buf_inst_q : imem_rdata;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        kill_d     = kill_q;
        buf_pc4_d  = buf_pc4_q;
        buf_inst_d = buf_inst_q;
        id_load    = 1'b0;
        id_flush   = 1'b0;

        if (redirect) begin
            pc_d       = target;
            id_flush   = 1'b1;
            state_d    = S_FETCH;
            buf_pc4_d  = '0;
            buf_inst_d = DATA_W'(ZeroWord);
            // An unacknowledged request cannot be withdrawn; its ack must be swallowed
            if ((state_q == S_FETCH) && !imem_ack) begin
                kill_d = 1'b1;
            end else begin
                kill_d     = 1'b0;
                req_addr_d = target;
            end
        end else if (state_q == S_FETCH) begin
            if (ack_ok) begin
                pc_d = req_plus4;
                if (!stall_ID) begin
                    id_load    = 1'b1;
                    req_addr_d = req_plus4;
                end else begin
                    buf_pc4_d  = req_plus4;
                    buf_inst_d = imem_rdata;
                    state_d    = S_HOLD;
                end
            end else begin
                if (imem_ack && kill_q) begin
                    kill_d     = 1'b0;
                    req_addr_d = pc_q;
                end
                if (!stall_ID) begin
                    id_flush = 1'b1;
                end
            end
        end else begin
            if (!stall_ID) begin
                id_load    = 1'b1;
                req_addr_d = pc_q;
                state_d    = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            kill_q     <= 1'b0;
            buf_pc4_q  <= '0;
            buf_inst_q <= DATA_W'(ZeroWord);
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            kill_q     <= kill_d;
            buf_pc4_q  <= buf_pc4_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign imem_req   = ~rst & (state_q == S_FETCH);
    assign imem_addr  = req_addr_q;
    assign fetch_busy = imem_req & ~imem_ack;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (id_flush),
        .load_i     (id_load),
        .pc_plus4_i (id_pc4),
        .inst_i     (id_inst),
        .pc_plus4_o (pc_plus4_ID),
        .inst_o     (inst_ID),
        .valid_o    (valid_ID)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage : directed checks of fetch, latency, redirect, kill, hold, wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_ID;
    logic        is_branch;
    logic [31:0] branch_address;
    logic        is_rst_IF_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
    logic        fetch_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instruction memory content: tag in the top half, address in the bottom half
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    if_fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_ID       (stall_ID),
        .is_branch      (is_branch),
        .branch_address (branch_address),
        .is_rst_IF_ID   (is_rst_IF_ID),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_plus4_ID    (pc_plus4_ID),
        .inst_ID        (inst_ID),
        .valid_ID       (valid_ID),
        .fetch_busy     (fetch_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc4,
                            input logic [31:0] inst, input logic vld);
        check({tag, ".pc4"},   pc_plus4_ID,     pc4);
        check({tag, ".inst"},  inst_ID,         inst);
        check({tag, ".valid"}, {31'b0, valid_ID}, {31'b0, vld});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"},  {31'b0, imem_req}, {31'b0, req});
        check({tag, ".addr"}, imem_addr,         addr);
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle
    task automatic drive(input logic r, input logic ack, input logic stall,
                         input logic br, input logic [31:0] ba);
        rst            = r;
        imem_ack       = ack;
        stall_ID       = stall;
        is_branch      = br;
        branch_address = ba;
        is_rst_IF_ID   = br;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();

        // Reset state: still in the reset cycle
        check_req("rst", 1'b0, 32'h0);
        check_id("rst", 32'h0, 32'h0, 1'b0);

        // 1: zero-wait stream
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t1c0", 1'b1, 32'h0);
        check("t1c0.busy", {31'b0, fetch_busy}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t1c1", 1'b1, 32'h4);
        check_id("t1c1", 32'h4, inst_of(32'h0), 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t1c2", 1'b1, 32'h8);
        check_id("t1c2", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t1c3", 1'b1, 32'hC);
        check_id("t1c3", 32'hC, inst_of(32'h8), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_id("t1c4", 32'h10, inst_of(32'hC), 1'b1);

        // 2: 3-cycle latency at 0x8
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_req("t2c2", 1'b1, 32'h8);
        check("t2c2.busy", {31'b0, fetch_busy}, 32'h1);
        check_id("t2c2", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_req("t2c3", 1'b1, 32'h8);
        check_id("t2c3", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t2c4", 1'b1, 32'h8);
        check_id("t2c4", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_req("t2c5", 1'b1, 32'hC);
        check_id("t2c5", 32'hC, inst_of(32'h8), 1'b1);

        // 3: taken branch to 0x40 (low bits must be ignored) with zero-wait memory
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h43);
        check_req("t3c2", 1'b1, 32'h8);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t3c3", 1'b1, 32'h40);
        check_id("t3c3", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_req("t3c4", 1'b1, 32'h44);
        check_id("t3c4", 32'h44, inst_of(32'h40), 1'b1);

        // 4: redirect to 0x100 while 0xC is outstanding
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        check_req("t4c3", 1'b1, 32'hC);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t4c4", 1'b1, 32'hC);
        check_id("t4c4", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t4c5", 1'b1, 32'h100);
        check_id("t4c5", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_id("t4c6", 32'h104, inst_of(32'h100), 1'b1);

        // 5: stall for 3 cycles with ack in the first; a branch under stall is ignored
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_id("t5c2", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        check("t5c3.req", {31'b0, imem_req}, 32'h0);
        check_id("t5c3", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t5c4.req", {31'b0, imem_req}, 32'h0);
        check_id("t5c4", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("t5c5.req", {31'b0, imem_req}, 32'h0);
        check_id("t5c5", 32'h8, inst_of(32'h4), 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t5c6", 1'b1, 32'hC);
        check_id("t5c6", 32'hC, inst_of(32'h8), 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_id("t5c7", 32'h10, inst_of(32'hC), 1'b1);

        // 6: wrap at 0xFFFF_FFFC, then reset while an ack is pending
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t6c1", 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_req("t6c2", 1'b1, 32'h0);
        check_id("t6c2", 32'h0, inst_of(32'hFFFF_FFFC), 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("t6c3.req", {31'b0, imem_req}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_req("t6c4", 1'b1, 32'h0);
        check_id("t6c4", 32'h0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_id("t6c5", 32'h4, inst_of(32'h0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
